// File: rtl/pmod_pwm.sv
`default_nettype none
// ============================================================================
// Module      : pmod_pwm
// Description : Eight-channel PWM generator for the PMOD header pins. A shared
//               prescaler and period counter feed one comparator per channel.
//               Duty values arrive over a valid/ready write port.
//               Optional feature macro: PMOD_PWM_SHADOW_EN
//                 defined   - writes land in per-channel shadow registers and
//                             are copied to the active duty registers at each
//                             period boundary (glitch-free updates).
//                 undefined - writes land in the active duty registers
//                             directly and take effect on the next clock.
// Revision    : 1.0 - initial release
// ============================================================================
module pmod_pwm #(
    parameter int PRESCALE = 390,
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 8
) (
    input  logic                CLK_100,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic                WR_VALID,
    output logic                WR_READY,
    input  logic [2:0]          WR_CH,
    input  logic [WIDTH-1:0]    WR_DUTY,
    output logic [CHANNELS-1:0] PWM_OUT,
    output logic                PERIOD_STROBE
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                   c_PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(PRESCALE - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
    localparam logic [WIDTH-1:0]     c_PCNT_LAST  = '1;
    localparam logic [WIDTH-1:0]     c_PCNT_ONE   = WIDTH'(1);

    // ------------------------------------------------------------------------
    // Shared timebase
    // ------------------------------------------------------------------------
    logic [c_PRESC_W-1:0] r_presc;
    logic [WIDTH-1:0]     r_pcnt;
    logic                 w_tick;
    logic                 w_commit;

    // Handshake and output registers
    logic                 r_live;
    logic                 w_accept;
    logic [CHANNELS-1:0]  w_pwm_next;
    logic [CHANNELS-1:0]  r_pwm;
    logic                 r_strobe;

    // A tick only exists while running; a stale prescaler value in the cycle
    // ENABLE drops must not advance the period counter or fire a commit.
    assign w_tick   = ENABLE && (r_presc == c_PRESC_LAST);

    // The last tick of a period is the commit point for shadowed duties and
    // the cycle in which the write port pauses.
    assign w_commit = w_tick && (r_pcnt == c_PCNT_LAST);

    // The write port is closed until the first clock after reset and during
    // the commit cycle, so a write can never race a shadow-to-active copy.
    assign WR_READY = r_live && !w_commit;
    assign w_accept = WR_VALID && WR_READY;

    // Prescaler: divides the system clock down to one PWM count per tick.
    always_ff @(posedge CLK_100 or posedge RESET) begin
        if (RESET) begin
            r_presc <= '0;
        end else if (!ENABLE || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_ONE;
        end
    end

    // Period counter: advances once per tick and wraps naturally at 2^WIDTH.
    always_ff @(posedge CLK_100 or posedge RESET) begin
        if (RESET) begin
            r_pcnt <= '0;
        end else if (!ENABLE) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= r_pcnt + c_PCNT_ONE;
        end
    end

    // Reset-release flag: opens the write port one clock after reset ends.
    always_ff @(posedge CLK_100 or posedge RESET) begin
        if (RESET) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel duty storage and comparator
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic             w_sel;
            logic [WIDTH-1:0] r_act;

            // Channel indices at or above CHANNELS never match, so such
            // writes complete the handshake and are simply dropped.
            assign w_sel = w_accept && (WR_CH == 3'(i));

`ifdef PMOD_PWM_SHADOW_EN
            logic [WIDTH-1:0] r_shd;

            // Shadow duty: collects every accepted write for this channel.
            always_ff @(posedge CLK_100 or posedge RESET) begin
                if (RESET) begin
                    r_shd <= '0;
                end else if (w_sel) begin
                    r_shd <= WR_DUTY;
                end
            end

            // Active duty: copied from the shadow at the period boundary, or
            // written directly while stopped since no period is in flight.
            always_ff @(posedge CLK_100 or posedge RESET) begin
                if (RESET) begin
                    r_act <= '0;
                end else if (w_commit) begin
                    r_act <= r_shd;
                end else if (w_sel && !ENABLE) begin
                    r_act <= WR_DUTY;
                end
            end
`else
            // Active duty: accepted writes take effect on the next clock.
            always_ff @(posedge CLK_100 or posedge RESET) begin
                if (RESET) begin
                    r_act <= '0;
                end else if (w_sel) begin
                    r_act <= WR_DUTY;
                end
            end
`endif

            // Output is high for the first r_act counts of every period.
            assign w_pwm_next[i] = (r_pcnt < r_act);
        end
    endgenerate

    // PWM output register: one clock behind the period counter, held low
    // while stopped.
    always_ff @(posedge CLK_100 or posedge RESET) begin
        if (RESET) begin
            r_pwm <= '0;
        end else if (!ENABLE) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_pwm_next;
        end
    end

    // Period strobe: one-clock pulse following each commit cycle.
    always_ff @(posedge CLK_100 or posedge RESET) begin
        if (RESET) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_commit;
        end
    end

    assign PWM_OUT       = r_pwm;
    assign PERIOD_STROBE = r_strobe;

endmodule
`default_nettype wire

// File: doc/pmod_pwm.md
# pmod_pwm

Eight-channel PWM generator driving the PMOD header pins (A or B bank) from the 100 MHz board clock. It replaces the raw counter-bit drive of the PMOD outputs with per-channel duty-cycle control. A shared prescaler and period counter feed one comparator per channel. Duty values arrive over a valid/ready write port from the control logic upstream.

## Interface
Parameters:
- PRESCALE, 390, system clocks per PWM count; legal range ≥ 2. The default gives ≈ 1 kHz PWM at 8-bit width.
- CHANNELS, 8, number of PWM outputs; legal range 1..8.
- WIDTH, 8, duty and period-counter width in bits.

Ports:
- CLK_100  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  runs the PWM when high; when low, counters clear and outputs are forced low.
- WR_VALID  in  1  duty write request.
- WR_READY  out  1  write port can accept.
- WR_CH  in  3  target channel index.
- WR_DUTY  in  WIDTH  duty value; the output is high for WR_DUTY of every 2^WIDTH counts.
- PWM_OUT  out  CHANNELS  registered PWM outputs, one per PMOD pin.
- PERIOD_STROBE  out  1  one-cycle pulse at each PWM period start.

## Operation
- Prescaler `presc`, range 0..PRESCALE-1:
  - Increments each clock while ENABLE=1.
  - `tick` is asserted combinationally when presc = PRESCALE-1; presc wraps to 0 on that clock.
- Period counter `pcnt`, WIDTH bits:
  - Increments on each tick.
  - Wraps from 2^WIDTH-1 to 0.
  - Period = PRESCALE·2^WIDTH clocks.
- Commit cycle: tick with pcnt = 2^WIDTH-1.
- Each channel holds an active duty register `act[i]`. PWM_OUT[i] is registered as (pcnt < act[i]).
  - Duty 0: output never high.
  - Duty 2^WIDTH-1: output low for exactly one count per period.
- Write handshake:
  - A transfer occurs on a clock where WR_VALID & WR_READY.
  - WR_READY=0 during reset and during the commit cycle; it is 1 otherwise.
  - Writes with WR_CH ≥ CHANNELS complete the handshake and are discarded.
  - Back-to-back writes are allowed, one per clock.
- ENABLE=0:
  - presc and pcnt clear to 0 synchronously.
  - PWM_OUT goes to 0 on the next clock.
  - PERIOD_STROBE stays 0 and writes are still accepted.
- When ENABLE rises, counting starts from presc=0, pcnt=0.

## Timing
- Reset values:
  - PWM_OUT=0, PERIOD_STROBE=0, WR_READY=0.
  - presc=0, pcnt=0.
  - All duty registers = 0.
- Reset is asynchronous: all outputs go low immediately on RESET rising, mid-period or not.
- WR_READY returns to 1 on the first clock after RESET deasserts.
- PWM_OUT lags pcnt by one clock.
- A duty change is visible on PWM_OUT no earlier than the clock after it lands in act[i].
- PERIOD_STROBE is high for exactly one clock, the clock after each commit cycle.
- A write presented during the commit cycle is stalled one clock and accepted on the next. With shadowing enabled it takes effect in the following period.

## Configuration
- Macro: PMOD_PWM_SHADOW_EN.
- Defined:
  - Each channel also has a shadow register `shd[i]`, and accepted writes load shd[i].
  - On every commit cycle, act[i] ← shd[i] for all channels, giving glitch-free updates at period boundaries.
  - While ENABLE=0, accepted writes load both shd[i] and act[i].
- Undefined:
  - No shadow registers exist; accepted writes load act[i] directly, effective the next clock.
  - WR_READY still drops in the commit cycle, so the handshake stays identical.

## Test plan
All scenarios use PRESCALE=4, WIDTH=8, CHANNELS=8, so period = 1024 clocks.
- Reset:
  - Stimulus: hold RESET 5 clocks with WR_VALID=1.
  - Required: WR_READY=0, PWM_OUT=0x00, no write accepted.
  - Required: WR_READY=1 on the first clock after release.
- Basic duty:
  - Stimulus: write ch0=64, then ENABLE=1.
  - Required (after one period with shadowing): PWM_OUT[0] is high exactly 256 clocks per 1024.
  - Required: PERIOD_STROBE pulses every 1024 clocks.
- Extremes:
  - Stimulus: ch1=0, ch2=255.
  - Required: PWM_OUT[1] is never high.
  - Required: PWM_OUT[2] is low exactly 4 clocks per period.
- Mid-period update:
  - Stimulus: running with ch3=32; write ch3=128 at pcnt=100.
  - Required with macro: the 32-duty period completes, and the 128 duty starts after the next PERIOD_STROBE.
  - Required without macro: PWM_OUT[3] rises at once, since pcnt < 128.
- Commit collision:
  - Stimulus: assert WR_VALID (ch4=200) in the commit cycle.
  - Required: WR_READY=0 that clock; the write is accepted next clock.
  - Required with macro: ch4 runs at 200 one period later.
- Async reset mid-run and ENABLE drop:
  - Stimulus: RESET at pcnt=150.
  - Required: PWM_OUT=0 without waiting for a clock edge, and all duties read back 0 after restart.
  - Stimulus: ENABLE=0 at pcnt=150 instead.
  - Required: PWM_OUT=0 on the next clock, and pcnt restarts at 0 when re-enabled.
- Out-of-range channel:
  - Stimulus: write WR_CH=7 with CHANNELS=6.
  - Required: handshake completes and no output changes.
